// File: rtl/sound_length_trig_bank.sv
// sound_length_trig_bank
//   Four independent length engines for the sound block. Each channel takes
//   trigger and disable requests from the register block over its own 4-phase
//   req/ack handshake and counts its length down once per clk_length_ctr edge.
//
// Ports
//   rst             async, active-high reset
//   clk_length_ctr  length clock, one rising edge = one length step
//   trig_req/ack    per-channel trigger handshake (bit i = channel i+1)
//   dis_req/ack     per-channel disable handshake (DAC off / power off)
//   single          1 = length-limited (counter runs), 0 = continuous
//   len1,len2,len4  W_SHORT length fields, latched on trigger accept
//   len3            W_LONG length field for ch3, latched on trigger accept
//   enable          channel sounding
//   expired         sticky: channel stopped by its length reaching zero
//   rem1,rem2,rem4  remaining steps (W_SHORT+1 bits)
//   rem3            remaining steps for ch3 (W_LONG+1 bits)
module sound_length_trig_bank #(
  parameter int W_SHORT = 6,
  parameter int W_LONG  = 8
) (
  input  logic               rst,
  input  logic               clk_length_ctr,
  input  logic [3:0]         trig_req,
  output logic [3:0]         trig_ack,
  input  logic [3:0]         dis_req,
  output logic [3:0]         dis_ack,
  input  logic [3:0]         single,
  input  logic [W_SHORT-1:0] len1,
  input  logic [W_SHORT-1:0] len2,
  input  logic [W_LONG-1:0]  len3,
  input  logic [W_SHORT-1:0] len4,
  output logic [3:0]         enable,
  output logic [3:0]         expired,
  output logic [W_SHORT:0]   rem1,
  output logic [W_SHORT:0]   rem2,
  output logic [W_LONG:0]    rem3,
  output logic [W_SHORT:0]   rem4
);

  typedef enum logic {
    CH_OFF = 1'b0,
    CH_ON  = 1'b1
  } ch_state_e;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    // ch3 (index 2) carries the wider length field.
    localparam int W = (i == 2) ? W_LONG : W_SHORT;
    // 2^W: a zero length field means the full range, so rem is one bit wider.
    localparam logic [W:0] FULL = {1'b1, {W{1'b0}}};
    localparam logic [W:0] ONE  = {{W{1'b0}}, 1'b1};

    logic [W-1:0] len;
    logic [W:0]   rem_q;
    logic [W:0]   reload;
    ch_state_e    state_q;
    logic         expired_q;
    logic         trig_ack_q;
    logic         dis_ack_q;
    logic         trig_acc;
    logic         dis_acc;

    if (i == 0) begin : g_io
      assign len  = len1;
      assign rem1 = rem_q;
    end else if (i == 1) begin : g_io
      assign len  = len2;
      assign rem2 = rem_q;
    end else if (i == 2) begin : g_io
      assign len  = len3;
      assign rem3 = rem_q;
    end else begin : g_io
      assign len  = len4;
      assign rem4 = rem_q;
    end

    assign reload   = FULL - {1'b0, len};
    // A request is taken only while its ack is low, so a held req fires once.
    assign trig_acc = trig_req[i] & ~trig_ack_q;
    assign dis_acc  = dis_req[i]  & ~dis_ack_q;

    always_ff @(posedge clk_length_ctr or posedge rst) begin
      if (rst) begin
        state_q    <= CH_OFF;
        expired_q  <= 1'b0;
        trig_ack_q <= 1'b0;
        dis_ack_q  <= 1'b0;
        rem_q      <= '0;
      end else begin
        // 4-phase: ack rises on accept, follows req low on the next edge.
        trig_ack_q <= trig_req[i];
        dis_ack_q  <= dis_req[i];
        // Priority: disable > trigger > count step.
        if (dis_acc) begin
          state_q <= CH_OFF;
          rem_q   <= '0;
        end else if (trig_acc) begin
          state_q   <= CH_ON;
          expired_q <= 1'b0;
          rem_q     <= reload;
        end else if (state_q == CH_ON && single[i]) begin
          if (rem_q > ONE) begin
            rem_q <= rem_q - ONE;
          end else begin
            rem_q     <= '0;
            state_q   <= CH_OFF;
            expired_q <= 1'b1;
          end
        end
      end
    end

    assign enable[i]   = (state_q == CH_ON);
    assign expired[i]  = expired_q;
    assign trig_ack[i] = trig_ack_q;
    assign dis_ack[i]  = dis_ack_q;
  end

endmodule
